// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the digit-serial add/subtract unit.
// The master drives operands and consumes results; the slave is the arithmetic unit.
interface serial_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             n;
  logic             v;
  logic             z;
  logic             c;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, n, v, z, c
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, n, v, z, c
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial signed add/subtract with registered N/V/Z/C flags and optional saturation.
// DIGIT bits are summed per cycle; one extra cycle turns the full raw sum into result and flags.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus,
  output logic            busy
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG + 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_step;
  logic                     w_final;
  logic                     w_digit_last;

  logic [CNT_W-1:0]         r_cnt;
  logic                     r_carry_p0;
  logic                     r_out_valid;

  logic [WIDTH-1:0]         r_a_p0;
  logic [WIDTH-1:0]         r_b_p0;
  logic [1:0]               r_op_p0;
  logic [WIDTH-1:0]         r_sum_p0;
  logic                     r_cmsb_p0;

  logic [DIGIT:0]           w_dsum;
  logic [WIDTH+DIGIT-1:0]   w_sum_cat;
  logic                     w_raw_v;
  logic signed [WIDTH-1:0]  w_sat;

  logic signed [WIDTH-1:0]  r_result_p1;
  logic                     r_n_p1;
  logic                     r_v_p1;
  logic                     r_z_p1;
  logic                     r_c_p1;

  function automatic logic signed [WIDTH-1:0] f_saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ovf,
    input logic                    sat_en
  );
    logic signed [WIDTH-1:0] lim;
    lim = raw;
    if (sat_en && ovf) begin
      // Overflow flips the sign bit, so a negative-looking raw sum came from positive overflow.
      lim = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
    return lim;
  endfunction

  assign bus.in_ready  = !rst && (r_state == S_IDLE || (r_state == S_DONE && bus.out_ready));
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_final       = (r_state == S_BUSY) && (r_cnt == CNT_W'(NDIG));
  assign w_step        = (r_state == S_BUSY) && !w_final;
  assign w_digit_last  = (r_cnt == CNT_W'(NDIG - 1));
  assign busy          = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: if (w_final) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = w_accept ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Stage p0: one digit per cycle, sum digits shifted in from the top.
  assign w_dsum    = {1'b0, r_a_p0[DIGIT-1:0]} + {1'b0, r_b_p0[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry_p0};
  assign w_sum_cat = {w_dsum[DIGIT-1:0], r_sum_p0} >> DIGIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_carry_p0  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_cnt      <= '0;
        r_carry_p0 <= bus.op[0];
      end else if (w_step) begin
        r_cnt      <= r_cnt + 1'b1;
        r_carry_p0 <= w_dsum[DIGIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p0  <= bus.a;
      r_b_p0  <= bus.b ^ {WIDTH{bus.op[0]}};
      r_op_p0 <= bus.op;
    end else if (w_step) begin
      r_a_p0   <= r_a_p0 >> DIGIT;
      r_b_p0   <= r_b_p0 >> DIGIT;
      r_sum_p0 <= w_sum_cat[WIDTH-1:0];
      // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
      if (w_digit_last)
        r_cmsb_p0 <= w_dsum[DIGIT-1] ^ r_a_p0[DIGIT-1] ^ r_b_p0[DIGIT-1];
    end
  end

  // Stage p1: flags and saturation from the full-width raw sum.
  assign w_raw_v = r_cmsb_p0 ^ r_carry_p0;
  assign w_sat   = f_saturate(r_sum_p0, w_raw_v, r_op_p0[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_p1 <= '0;
      r_n_p1      <= 1'b0;
      r_v_p1      <= 1'b0;
      r_z_p1      <= 1'b0;
      r_c_p1      <= 1'b0;
    end else if (w_final) begin
      r_result_p1 <= w_sat;
      r_n_p1      <= w_sat[WIDTH-1];
      r_v_p1      <= w_raw_v;
      r_z_p1      <= (w_sat == '0);
      r_c_p1      <= r_carry_p0 ^ r_op_p0[0];
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result_p1;
  assign bus.n         = r_n_p1;
  assign bus.v         = r_v_p1;
  assign bus.z         = r_z_p1;
  assign bus.c         = r_c_p1;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: a 4-bit-digit instance plus a single-digit instance.
// Expected {result,n,v,z,c} come from an integer-arithmetic reference model.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy4;
  logic busy16;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ov_rises = 0;
  logic ov_prev = 1'b0;
  int   acc_edge = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(16)) u_if ();
  serial_addsub_if #(.WIDTH(16)) u_if2 ();

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .bus(u_if), .busy(busy4)
  );
  serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(u_if2), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    int sa, sb, ex;
    logic [15:0] res;
    logic v, c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ex = op[0] ? sa - sb : sa + sb;
    v = (ex > 32767) || (ex < -32768);
    res = 16'(ex);
    if (op[1] && v) res = (ex > 0) ? 16'h7FFF : 16'h8000;
    c = op[0] ? (a < b) : ((32'(a) + 32'(b)) > 32'h0000FFFF);
    return {res, res[15], v, (res == 16'h0000), c};
  endfunction

  // Scoreboard monitor: a transfer completes on the edge after out_valid & out_ready is seen.
  always @(negedge clk) begin
    if (u_if.out_valid && !ov_prev) ov_rises++;
    ov_prev = u_if.out_valid;
    if (!rst && u_if.out_valid && u_if.out_ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("res_flags", {12'h0, u_if.result, u_if.n, u_if.v, u_if.z, u_if.c},
                 {12'h0, sb_q.pop_front()});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    bit done = 0;
    u_if.in_valid = 1'b1;
    u_if.a = a;
    u_if.b = b;
    u_if.op = op;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (u_if.in_ready) begin
        sb_q.push_back(model(a, b, op));
        acc_edge = cyc + 1;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    u_if.in_valid = 1'b0;
    u_if.a = 16'($urandom);
    u_if.b = 16'($urandom);
    u_if.op = 2'($urandom);
  endtask

  task automatic wait_ov(input string tag, input int exp_lat);
    bit seen = 0;
    int lat = -1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (u_if.out_valid) begin
        seen = 1;
        lat = cyc - acc_edge;
      end
    end
    @(posedge clk);
    #1;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    else check(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [19:0] hold_exp;
    int rises_before;
    int lat16;
    bit seen16;
    u_if.in_valid = 1'b0; u_if.a = '0; u_if.b = '0; u_if.op = '0; u_if.out_ready = 1'b1;
    u_if2.in_valid = 1'b0; u_if2.a = '0; u_if2.b = '0; u_if2.op = '0; u_if2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(u_if.in_ready), 32'd0);
    check("rst_outputs", {26'h0, u_if.out_valid, u_if.n, u_if.v, u_if.z, u_if.c, busy4}, 32'd0);
    check("rst_result", 32'(u_if.result), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(u_if.in_ready), 32'd1);

    send(16'h7FFF, 16'h0001, 2'b00); wait_ov("lat_add_ovf", 5);
    send(16'h7FFF, 16'h0001, 2'b10); wait_ov("lat_adds_sat", 5);
    send(16'h0005, 16'h0005, 2'b01); wait_ov("lat_sub_zero", 5);
    send(16'h0003, 16'h0005, 2'b01); wait_ov("lat_sub_neg", 5);
    send(16'h8000, 16'h0001, 2'b11); wait_ov("lat_subs_sat", 5);
    send(16'hFFFF, 16'h0001, 2'b00); wait_ov("lat_add_wrap", 5);
    send(16'h8000, 16'h8000, 2'b10); wait_ov("lat_adds_negsat", 5);

    // Stall in DONE, then drain and accept on the same edge.
    u_if.out_ready = 1'b0;
    send(16'h1234, 16'h0F0F, 2'b01);
    hold_exp = model(16'h1234, 16'h0F0F, 2'b01);
    wait_ov("lat_stall", 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_vals", {12'h0, u_if.result, u_if.n, u_if.v, u_if.z, u_if.c}, {12'h0, hold_exp});
      check("hold_ready", {30'h0, u_if.out_valid, u_if.in_ready}, 32'h2);
    end
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b1;
    send(16'h4000, 16'h4000, 2'b00);
    check("b2b_ov_low", {30'h0, u_if.out_valid, busy4}, 32'h1);
    wait_ov("lat_b2b", 5);

    for (int k = 0; k < 12; k++) begin
      send(16'($urandom), 16'($urandom), 2'($urandom));
      wait_ov("lat_rand", 5);
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset during the second BUSY cycle aborts the operation.
    rises_before = ov_rises;
    send(16'h7FFF, 16'h0001, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(u_if.in_ready), 32'd0);
    check("abort_outputs", {26'h0, u_if.out_valid, u_if.n, u_if.v, u_if.z, u_if.c, busy4}, 32'd0);
    check("abort_result", 32'(u_if.result), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_rel", 32'(u_if.in_ready), 32'd1);
    sb_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_ov", 32'(ov_rises), 32'(rises_before));

    // Single-digit instance: two-edge latency.
    u_if2.in_valid = 1'b1; u_if2.a = 16'h7FFF; u_if2.b = 16'h0001; u_if2.op = 2'b00;
    @(negedge clk);
    check("d16_in_ready", 32'(u_if2.in_ready), 32'd1);
    acc_edge = cyc + 1;
    @(posedge clk);
    #1;
    u_if2.in_valid = 1'b0;
    seen16 = 0;
    lat16 = -1;
    for (int i = 0; i < 20 && !seen16; i++) begin
      @(negedge clk);
      if (u_if2.out_valid) begin
        seen16 = 1;
        lat16 = cyc - acc_edge;
      end
    end
    check("d16_lat", 32'(lat16), 32'd2);
    check("d16_res_flags", {12'h0, u_if2.result, u_if2.n, u_if2.v, u_if2.z, u_if2.c},
          {12'h0, model(16'h7FFF, 16'h0001, 2'b00)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
